p66b_txgearbox: RTL and testbench

//  Parametrised TX gearbox: packs IW-bit PCS blocks (64b/66b by default) into
//  an OW-bit serial stream for the transceiver, LSB first. Sits between the
//  66b encoder/scrambler and the GT TX data port. Adds an AXI-style S_VALID

---
 rtl/p66b_txgearbox_if.sv | 12 +
 rtl/p66b_txgearbox.sv | 91 +++++++++
 tb/tb_p66b_txgearbox.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/p66b_txgearbox_if.sv
// Block-stream handshake between the 66b encoder/scrambler and the TX gearbox.
// The source drives S_VALID/S_DATA; the gearbox answers with S_READY.
interface p66b_txgearbox_if #(
    parameter int IW = 66
);
    logic          S_VALID;
    logic          S_READY;
    logic [IW-1:0] S_DATA;

    modport master (output S_VALID, output S_DATA, input S_READY);
    modport slave  (input S_VALID, input S_DATA, output S_READY);
endinterface

// File: rtl/p66b_txgearbox.sv
// TX gearbox: packs IW-bit PCS blocks into an OW-bit word stream, LSB first,
// and substitutes IDLE_WORD whenever a load slot finds no valid block.
module p66b_txgearbox #(
    parameter int            IW        = 66,
    parameter int            OW        = 64,
    parameter int            CW        = 16,
    parameter logic [IW-1:0] IDLE_WORD = {{(IW-10){1'b0}}, 8'h1e, 2'b10}
) (
    input  logic                i_clk,
    input  logic                i_reset,
    p66b_txgearbox_if.slave     s,
    input  logic                i_ready,
    output logic [OW-1:0]       o_data,
    output logic                o_idle,
    output logic [CW-1:0]       o_underflows
);
    localparam int BW = IW + OW;
    localparam int FW = $clog2(IW + OW + 1);

    if ((IW < OW) || (IW > 4 * OW)) begin : g_bad_params
        $error("p66b_txgearbox: IW must satisfy OW <= IW <= 4*OW");
    end

    logic [BW-1:0] buf_r;
    logic [BW-1:0] buf_nxt_s;
    logic [FW-1:0] fill_r;
    logic [FW-1:0] fill_nxt_s;
    logic          idle_r;
    logic          idle_nxt_s;
    logic [CW-1:0] unf_r;
    logic [CW-1:0] unf_nxt_s;
    logic          load_s;
    logic [IW-1:0] word_s;
    logic [BW-1:0] word_ext_s;

    // Load decision, word selection and next buffer/fill/counter values.
    always_comb begin
        load_s     = i_ready && (fill_r < FW'(2 * OW));
        word_s     = s.S_VALID ? s.S_DATA : IDLE_WORD;
        word_ext_s = {{OW{1'b0}}, word_s};
        buf_nxt_s  = buf_r;
        fill_nxt_s = fill_r;
        idle_nxt_s = 1'b0;
        unf_nxt_s  = unf_r;
        if (i_ready) begin
            buf_nxt_s  = buf_r >> OW;
            fill_nxt_s = fill_r - FW'(OW);
            if (load_s) begin
                // New block lands right above the bits still pending after this beat.
                buf_nxt_s  = buf_nxt_s | (word_ext_s << (fill_r - FW'(OW)));
                fill_nxt_s = fill_nxt_s + FW'(IW);
                if (!s.S_VALID) begin
                    idle_nxt_s = 1'b1;
                    if (unf_r != {CW{1'b1}}) begin
                        unf_nxt_s = unf_r + CW'(1);
                    end else begin
                        unf_nxt_s = unf_r;
                    end
                end else begin
                    idle_nxt_s = 1'b0;
                end
            end else begin
                idle_nxt_s = 1'b0;
            end
        end else begin
            buf_nxt_s  = buf_r;
            fill_nxt_s = fill_r;
        end
    end

    // State register; reset primes OW zero bits so output starts immediately.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            buf_r  <= {BW{1'b0}};
            fill_r <= FW'(OW);
            idle_r <= 1'b0;
            unf_r  <= {CW{1'b0}};
        end else begin
            buf_r  <= buf_nxt_s;
            fill_r <= fill_nxt_s;
            idle_r <= idle_nxt_s;
            unf_r  <= unf_nxt_s;
        end
    end

    assign s.S_READY    = load_s && !i_reset;
    assign o_data       = buf_r[OW-1:0];
    assign o_idle       = idle_r;
    assign o_underflows = unf_r;

endmodule

// File: tb/tb_p66b_txgearbox.sv
// Bench for p66b_txgearbox: two instances (66->64 with 16-bit counter, 66->32
// with 4-bit counter) checked against a bit-queue model of the output stream.
module tb_p66b_txgearbox;
    localparam logic [65:0] IDLE = 66'h7a;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    p66b_txgearbox_if #(.IW(66)) if_a ();
    p66b_txgearbox_if #(.IW(66)) if_b ();

    logic        ra, rb;
    logic [63:0] od_a;
    logic [31:0] od_b;
    logic        idle_a, idle_b;
    logic [15:0] unf_a;
    logic [3:0]  unf_b;

    p66b_txgearbox #(.IW(66), .OW(64), .CW(16)) dut_a (
        .i_clk(clk), .i_reset(rst), .s(if_a), .i_ready(ra),
        .o_data(od_a), .o_idle(idle_a), .o_underflows(unf_a)
    );

    p66b_txgearbox #(.IW(66), .OW(32), .CW(4)) dut_b (
        .i_clk(clk), .i_reset(rst), .s(if_b), .i_ready(rb),
        .o_data(od_b), .o_idle(idle_b), .o_underflows(unf_b)
    );

    logic [65:0] blocks [0:1023];
    int  ka, kb;
    bit  qa [$];
    bit  qb [$];
    int  ua, ub;
    bit  ei_a, ei_b;
    int  acc_a, acc_b;
    int  n_cmp, n_bad;

    task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        repeat (64) qa.push_back(1'b0);
        repeat (32) qb.push_back(1'b0);
        ua = 0; ub = 0; ei_a = 1'b0; ei_b = 1'b0;
    endtask

    // One clock: drive at negedge, check just after, then advance the model.
    task automatic beat(input bit va, input bit vb, input bit rav, input bit rbv);
        logic [65:0] exp;
        logic [65:0] w;
        bit la, lb;
        @(negedge clk);
        if_a.S_VALID = va; if_a.S_DATA = va ? blocks[ka] : ~blocks[ka];
        if_b.S_VALID = vb; if_b.S_DATA = vb ? blocks[kb] : ~blocks[kb];
        ra = rav; rb = rbv;
        #1;
        exp = '0;
        for (int i = 0; i < 64; i++) exp[i] = qa[i];
        chk("a_data", 66'(od_a), exp);
        la = rav && (qa.size() < 128);
        chk("a_ready", 66'(if_a.S_READY), 66'(la));
        chk("a_idle", 66'(idle_a), 66'(ei_a));
        chk("a_unf", 66'(unf_a), 66'(ua));
        exp = '0;
        for (int i = 0; i < 32; i++) exp[i] = qb[i];
        chk("b_data", 66'(od_b), exp);
        lb = rbv && (qb.size() < 64);
        chk("b_ready", 66'(if_b.S_READY), 66'(lb));
        chk("b_idle", 66'(idle_b), 66'(ei_b));
        chk("b_unf", 66'(unf_b), 66'(ub));
        if (if_a.S_READY === 1'b1) acc_a++;
        if (if_b.S_READY === 1'b1) acc_b++;
        ei_a = la && !va;
        ei_b = lb && !vb;
        if (la) begin
            w = va ? blocks[ka] : IDLE;
            for (int i = 0; i < 66; i++) qa.push_back(w[i]);
            if (va) ka++;
            else if (ua < 65535) ua++;
        end
        if (rav) repeat (64) void'(qa.pop_front());
        if (lb) begin
            w = vb ? blocks[kb] : IDLE;
            for (int i = 0; i < 66; i++) qb.push_back(w[i]);
            if (vb) kb++;
            else if (ub < 15) ub++;
        end
        if (rbv) repeat (32) void'(qb.pop_front());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; ra = 1'b1; rb = 1'b1;
        if_a.S_VALID = 1'b1; if_b.S_VALID = 1'b1;
        #1;
        chk("a_ready_in_reset", 66'(if_a.S_READY), 66'(0));
        chk("b_ready_in_reset", 66'(if_b.S_READY), 66'(0));
        @(negedge clk);
        rst = 1'b0; ra = 1'b0; rb = 1'b0;
        #1;
        chk("a_data_after_reset", 66'(od_a), 66'(0));
        chk("b_data_after_reset", 66'(od_b), 66'(0));
        chk("a_unf_after_reset", 66'(unf_a), 66'(0));
        chk("b_unf_after_reset", 66'(unf_b), 66'(0));
        chk("a_idle_after_reset", 66'(idle_a), 66'(0));
        model_reset();
    endtask

    initial begin
        logic [95:0] t;
        n_cmp = 0; n_bad = 0; ka = 0; kb = 0; acc_a = 0; acc_b = 0;
        rst = 1'b1; ra = 1'b0; rb = 1'b0;
        if_a.S_VALID = 1'b0; if_a.S_DATA = '0;
        if_b.S_VALID = 1'b0; if_b.S_DATA = '0;
        for (int i = 0; i < 1024; i++) begin
            t = {$urandom(), $urandom(), $urandom()};
            blocks[i] = t[65:0];
        end
        model_reset();
        do_reset();

        // Underflow: a misses its first 3 load slots, b misses 20 to saturate.
        for (int i = 0; i < 40; i++) beat(i >= 3, 1'b0, 1'b1, 1'b1);
        beat(1'b1, 1'b1, 1'b1, 1'b1);
        chk("a_unf_three", 66'(unf_a), 66'(3));
        chk("b_unf_saturated", 66'(unf_b), 66'(4'hf));

        // Continuous flow: any 33 ready beats hold 32 (a) / 16 (b) accepts.
        acc_a = 0; acc_b = 0;
        for (int i = 0; i < 33; i++) beat(1'b1, 1'b1, 1'b1, 1'b1);
        chk("a_accepts_per_33", 66'(acc_a), 66'(32));
        chk("b_accepts_per_33", 66'(acc_b), 66'(16));
        for (int i = 0; i < 40; i++) beat(1'b1, 1'b1, 1'b1, 1'b1);

        // Random transceiver stalls and occasional source gaps.
        for (int i = 0; i < 400; i++)
            beat($urandom_range(0, 9) != 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);

        // Reset in the middle of a partially sent block, then restart.
        do_reset();
        for (int i = 0; i < 70; i++) beat(1'b1, 1'b1, 1'b1, 1'b1);
        chk("a_unf_post_reset", 66'(unf_a), 66'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
